score_digit_sequencer: RTL and testbench

Sequences the shared 25x30 digit-glyph ROM bank to draw a DIGITS-wide decimal score on the VGA raster. Sits between the VGA timing generator and the pixel colour mux. Each pixel it maps the raster coordinate to a digit slot, issues row/col/digit-select to the ROM bank, and realigns the ROM's one-cycle read data with a hit flag. The score is snapshotted once per frame so the display never tears mid-frame.

---
 rtl/score_digit_sequencer_if.sv | 28 ++
 rtl/score_digit_sequencer.sv | 131 +++++++++++++
 tb/tb_score_digit_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/score_digit_sequencer_if.sv
// rtl/score_digit_sequencer_if.sv - raster, score, ROM-bank and pixel-output bundle for the score sequencer
interface score_digit_sequencer_if #(
    parameter int DIGITS = 4
);
    logic [9:0]          pixel_x;
    logic [9:0]          pixel_y;
    logic                video_on;
    logic                frame_start;
    logic [4*DIGITS-1:0] score_bcd;
    logic                blink_en;
    logic [4:0]          rom_row;
    logic [4:0]          rom_col;
    logic [3:0]          rom_digit;
    logic [11:0]         rom_color;
    logic [11:0]         color_out;
    logic                in_box;
    logic                bcd_error;

    modport master (
        output pixel_x, pixel_y, video_on, frame_start, score_bcd, blink_en, rom_color,
        input  rom_row, rom_col, rom_digit, color_out, in_box, bcd_error
    );

    modport slave (
        input  pixel_x, pixel_y, video_on, frame_start, score_bcd, blink_en, rom_color,
        output rom_row, rom_col, rom_digit, color_out, in_box, bcd_error
    );
endinterface

// File: rtl/score_digit_sequencer.sv
// rtl/score_digit_sequencer.sv - maps the raster onto decimal score glyph slots and realigns ROM colour data
module score_digit_sequencer #(
    parameter int          X0     = 400,
    parameter int          Y0     = 20,
    parameter int          DIGITS = 4,
    parameter int          PITCH  = 30,
    parameter logic [11:0] BG     = 12'h000
) (
    input  logic                  clk,
    input  logic                  reset,
    score_digit_sequencer_if.slave bus
);
    localparam int SW      = 4 * DIGITS;
    localparam int GLYPH_W = 25;
    localparam int GLYPH_H = 30;

    logic [SW-1:0]     score_q;
    logic [5:0]        frame_cnt;
    logic              bcd_error_q;
    logic              hit1;
    logic              hit2;
    logic [4:0]        row_q;
    logic [4:0]        col_q;
    logic [3:0]        digit_q;
    logic [11:0]       color_q;
    logic              in_box_q;

    logic [9:0]        dx;
    logic [9:0]        dy;
    logic [9:0]        base;
    logic [9:0]        off;
    logic [2:0]        slot;
    logic [3:0]        nib;
    logic              supp;
    logic              run_zero;
    logic [DIGITS-1:0] zero_prefix;
    logic              snap_bad;
    logic              visible;
    logic              hit_c;

    // Slot index via comparator chain against multiples of PITCH; the last match wins.
    always_comb begin
        dx   = bus.pixel_x - 10'(X0);
        dy   = bus.pixel_y - 10'(Y0);
        slot = 3'd0;
        base = 10'd0;
        for (int k = 1; k <= DIGITS; k++) begin
            if (dx >= 10'(k * PITCH)) begin
                slot = 3'(k);
                base = 10'(k * PITCH);
            end
        end
        off = dx - base;
    end

    // Leading-zero blanking; the least significant slot always shows.
    always_comb begin
        run_zero    = 1'b1;
        zero_prefix = '0;
        for (int i = 0; i < DIGITS; i++) begin
            run_zero       = run_zero & (score_q[4*(DIGITS-1-i) +: 4] == 4'd0);
            zero_prefix[i] = run_zero & (i != DIGITS - 1);
        end
    end

    always_comb begin
        nib  = 4'd0;
        supp = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (slot == 3'(i)) begin
                nib  = score_q[4*(DIGITS-1-i) +: 4];
                supp = zero_prefix[i];
            end
        end
    end

    always_comb begin
        snap_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.score_bcd[4*i +: 4] > 4'd9) begin
                snap_bad = 1'b1;
            end
        end
    end

    assign visible = !bus.blink_en | !frame_cnt[5];

    assign hit_c = bus.video_on & visible
                 & (bus.pixel_x >= 10'(X0)) & (slot < 3'(DIGITS)) & (off < 10'(GLYPH_W))
                 & (bus.pixel_y >= 10'(Y0)) & (dy < 10'(GLYPH_H))
                 & !supp & (nib <= 4'd9);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score_q     <= '0;
            frame_cnt   <= 6'd0;
            bcd_error_q <= 1'b0;
            hit1        <= 1'b0;
            hit2        <= 1'b0;
            row_q       <= 5'd0;
            col_q       <= 5'd0;
            digit_q     <= 4'd0;
            color_q     <= BG;
            in_box_q    <= 1'b0;
        end else begin
            // A glyph pixel in the snapshot cycle still sees the old score_q.
            if (bus.frame_start) begin
                score_q   <= bus.score_bcd;
                frame_cnt <= frame_cnt + 6'd1;
                if (snap_bad) begin
                    bcd_error_q <= 1'b1;
                end
            end
            hit1    <= hit_c;
            row_q   <= hit_c ? dy[4:0]  : 5'd0;
            col_q   <= hit_c ? off[4:0] : 5'd0;
            digit_q <= hit_c ? nib      : 4'd0;
            // hit2 lines up with the ROM's registered read of the stage-1 address.
            hit2     <= hit1;
            color_q  <= hit2 ? bus.rom_color : BG;
            in_box_q <= hit2;
        end
    end

    assign bus.rom_row   = row_q;
    assign bus.rom_col   = col_q;
    assign bus.rom_digit = digit_q;
    assign bus.color_out = color_q;
    assign bus.in_box    = in_box_q;
    assign bus.bcd_error = bcd_error_q;
endmodule

// File: tb/tb_score_digit_sequencer.sv
// tb/tb_score_digit_sequencer.sv - directed self-checking bench for score_digit_sequencer
module tb_score_digit_sequencer;
    localparam logic [11:0] BG = 12'h000;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   fcnt;
    logic [15:0] ref_score;
    logic        ref_err;

    score_digit_sequencer_if #(.DIGITS(4)) bus ();

    score_digit_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] rom_fn(input logic [3:0] d, input logic [4:0] c, input logic [4:0] r);
        return 12'(int'(d) * 291 + int'(c) * 17 + int'(r) * 3 + 1);
    endfunction

    // Behavioural glyph ROM bank with its one-cycle registered read.
    always @(posedge clk) bus.rom_color <= rom_fn(bus.rom_digit, bus.rom_col, bus.rom_row);

    function automatic void model(input logic [15:0] sc, input int x, input int y, input bit vis,
                                  output logic box, output logic [11:0] col);
        int first;
        int left;
        logic [3:0] n;
        box   = 1'b0;
        col   = BG;
        first = 3;
        for (int s = 3; s >= 0; s--) if (sc[4*(3-s) +: 4] != 4'd0) first = s;
        for (int s = 0; s < 4; s++) begin
            left = 400 + 30 * s;
            n    = sc[4*(3-s) +: 4];
            if (vis && x >= left && x <= left + 24 && y >= 20 && y <= 49 && s >= first && n <= 4'd9) begin
                box = 1'b1;
                col = rom_fn(n, 5'(x - left), 5'(y - 20));
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        bus.video_on    = 1'b0;
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        ref_score = bus.score_bcd;
        for (int i = 0; i < 4; i++) if (bus.score_bcd[4*i +: 4] > 4'd9) ref_err = 1'b1;
        fcnt++;
    endtask

    task automatic load_score(input logic [15:0] sc);
        bus.score_bcd = sc;
        pulse_frame();
    endtask

    // Streams one pixel per clock and checks each output three edges after its pixel.
    task automatic scan(input string tag, input int y, input int xa, input int xb);
        logic       qb[$];
        logic [11:0] qc[$];
        logic       b;
        logic [11:0] c;
        bit         vis;
        int         cnt;
        vis = !bus.blink_en || (fcnt % 64) < 32;
        cnt = xb - xa + 1;
        for (int n = 0; n < cnt + 3; n++) begin
            @(negedge clk);
            if (n >= 3) begin
                b = qb.pop_front();
                c = qc.pop_front();
                check({tag, "_box"}, {31'd0, bus.in_box}, {31'd0, b});
                check({tag, "_color"}, {20'd0, bus.color_out}, {20'd0, c});
            end
            if (n < cnt) begin
                bus.pixel_x  = 10'(xa + n);
                bus.pixel_y  = 10'(y);
                bus.video_on = 1'b1;
                model(ref_score, xa + n, y, vis, b, c);
                qb.push_back(b);
                qc.push_back(c);
            end else begin
                bus.video_on = 1'b0;
            end
        end
    endtask

    task automatic probe_rom(input string tag, input int x, input int y,
                             input logic [3:0] ed, input logic [4:0] er, input logic [4:0] ec);
        @(negedge clk);
        bus.pixel_x  = 10'(x);
        bus.pixel_y  = 10'(y);
        bus.video_on = 1'b1;
        @(negedge clk);
        check({tag, "_digit"}, {28'd0, bus.rom_digit}, {28'd0, ed});
        check({tag, "_row"}, {27'd0, bus.rom_row}, {27'd0, er});
        check({tag, "_col"}, {27'd0, bus.rom_col}, {27'd0, ec});
        bus.video_on = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks          = 0;
        errors          = 0;
        fcnt            = 0;
        ref_score       = 16'h0000;
        ref_err         = 1'b0;
        reset           = 1'b1;
        bus.pixel_x     = '0;
        bus.pixel_y     = '0;
        bus.video_on    = 1'b0;
        bus.frame_start = 1'b0;
        bus.score_bcd   = '0;
        bus.blink_en    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_row", {27'd0, bus.rom_row}, 32'd0);
        check("rst_col", {27'd0, bus.rom_col}, 32'd0);
        check("rst_digit", {28'd0, bus.rom_digit}, 32'd0);
        check("rst_color", {20'd0, bus.color_out}, {20'd0, BG});
        check("rst_box", {31'd0, bus.in_box}, 32'd0);
        check("rst_err", {31'd0, bus.bcd_error}, 32'd0);
        reset = 1'b0;

        load_score(16'h1234);
        scan("s1234_y20", 20, 400, 519);
        scan("s1234_y49", 49, 398, 522);
        probe_rom("p0", 405, 25, 4'd1, 5'd5, 5'd5);
        probe_rom("p1", 432, 20, 4'd2, 5'd0, 5'd2);
        probe_rom("p2", 484, 49, 4'd3, 5'd29, 5'd24);
        probe_rom("p3", 514, 30, 4'd4, 5'd10, 5'd24);
        probe_rom("pgap", 455, 30, 4'd0, 5'd0, 5'd0);

        load_score(16'h0007);
        scan("s0007", 25, 400, 519);
        load_score(16'h0000);
        scan("s0000", 25, 400, 519);
        load_score(16'h0105);
        scan("s0105", 25, 400, 519);

        bus.score_bcd = 16'h9999;
        scan("midframe", 30, 400, 519);
        pulse_frame();
        scan("s9999", 30, 400, 519);

        load_score(16'h12A4);
        scan("s12a4", 25, 400, 519);
        check("err_set", {31'd0, bus.bcd_error}, {31'd0, ref_err});
        load_score(16'h1234);
        check("err_sticky", {31'd0, bus.bcd_error}, {31'd0, ref_err});

        scan("edge_399_20", 20, 399, 399);
        scan("edge_400_19", 19, 400, 400);
        scan("edge_400_50", 50, 400, 400);
        scan("edge_515_25", 25, 515, 515);

        @(negedge clk);
        bus.pixel_x  = 10'd410;
        bus.pixel_y  = 10'd25;
        bus.video_on = 1'b1;
        repeat (4) @(negedge clk);
        check("pre_reset_box", {31'd0, bus.in_box}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_box", {31'd0, bus.in_box}, 32'd0);
        check("async_rst_color", {20'd0, bus.color_out}, {20'd0, BG});
        check("async_rst_digit", {28'd0, bus.rom_digit}, 32'd0);
        check("async_rst_err", {31'd0, bus.bcd_error}, 32'd0);
        ref_score = 16'h0000;
        ref_err   = 1'b0;
        fcnt      = 0;
        @(negedge clk);
        bus.video_on = 1'b0;
        reset        = 1'b0;
        scan("post_reset", 25, 400, 519);

        bus.blink_en = 1'b1;
        for (int f = 0; f <= 64; f++) begin
            scan("blink", 25, 489, 491);
            pulse_frame();
        end
        bus.blink_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
